multi_phase_signal_ctrl: RTL and testbench

MULTI_PHASE_SIGNAL_CTRL -- requirements
Module: multi_phase_signal_ctrl

---
 rtl/multi_phase_signal_ctrl.sv | 257 +++++++++++++++++++++++++
 tb/tb_multi_phase_signal_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/multi_phase_signal_ctrl.sv
// multi_phase_signal_ctrl
// Round-robin multi-phase traffic signal controller. Each phase gets a
// GREEN -> YELLOW -> ALLRED sequence; detector requests are latched as
// per-phase pending flags and served in index order after the current phase.
// Optional night flash mode is compiled in by defining NIGHT_FLASH_EN; without
// it the night input is accepted but has no effect and no FLASH state exists.
module multi_phase_signal_ctrl #(
    parameter int NUM_DIR   = 4,
    parameter int GREEN_MIN = 8,
    parameter int GREEN_MAX = 20,
    parameter int YELLOW_T  = 3,
    parameter int ALLRED_T  = 2,
    parameter int FLASH_T   = 4,
    parameter int TIMER_W   = 8
) (
    input  logic                   clock,
    input  logic                   clear_n,
    input  logic [NUM_DIR-1:0]     req,
    input  logic                   night,
    output logic [2*NUM_DIR-1:0]   light,
    output logic [2:0]             active_phase,
    output logic                   phase_start
);

    // Largest count any timer has to reach.
    localparam int MAX_T = (GREEN_MAX > YELLOW_T) ?
                           ((GREEN_MAX > ALLRED_T) ? ((GREEN_MAX > FLASH_T) ? GREEN_MAX : FLASH_T)
                                                   : ((ALLRED_T > FLASH_T) ? ALLRED_T : FLASH_T)) :
                           ((YELLOW_T > ALLRED_T) ? ((YELLOW_T > FLASH_T) ? YELLOW_T : FLASH_T)
                                                  : ((ALLRED_T > FLASH_T) ? ALLRED_T : FLASH_T));

    // Elaboration-time parameter sanity.
    if (NUM_DIR < 2 || NUM_DIR > 8) begin : g_bad_num_dir
        $error("NUM_DIR must be in 2..8");
    end
    if (GREEN_MAX < GREEN_MIN || GREEN_MIN < 1) begin : g_bad_green
        $error("GREEN_MAX must be >= GREEN_MIN >= 1");
    end
    if ((MAX_T - 1) >= (1 << TIMER_W)) begin : g_bad_timer_w
        $error("TIMER_W too small for the longest interval");
    end

    localparam logic [1:0] LAMP_RED = 2'b00;
    localparam logic [1:0] LAMP_YEL = 2'b01;
    localparam logic [1:0] LAMP_GRN = 2'b11;

    localparam logic [TIMER_W-1:0] T_GMIN = TIMER_W'(GREEN_MIN - 1);
    localparam logic [TIMER_W-1:0] T_GMAX = TIMER_W'(GREEN_MAX - 1);
    localparam logic [TIMER_W-1:0] T_YEL  = TIMER_W'(YELLOW_T - 1);
    localparam logic [TIMER_W-1:0] T_AR   = TIMER_W'(ALLRED_T - 1);
`ifdef NIGHT_FLASH_EN
    localparam logic [TIMER_W-1:0] T_FL   = TIMER_W'(FLASH_T - 1);
`endif

    // Reset lamp word: phase 0 green, everything else red.
    localparam logic [2*NUM_DIR-1:0] LIGHT_RST = (2*NUM_DIR)'(LAMP_GRN);

`ifdef NIGHT_FLASH_EN
    typedef enum logic [1:0] {S_GREEN, S_YELLOW, S_ALLRED, S_FLASH} state_t;
`else
    typedef enum logic [1:0] {S_GREEN, S_YELLOW, S_ALLRED} state_t;
`endif

    state_t               r_state, w_state_nxt;
    logic [TIMER_W-1:0]   r_timer, w_timer_nxt;
    logic [2:0]           r_active, w_active_nxt;
    logic [NUM_DIR-1:0]   r_pending, w_pending_nxt;
    logic [2*NUM_DIR-1:0] r_light, w_light_nxt;
    logic                 r_phase_start, w_phase_start_nxt;
    logic                 w_enter_green;
    logic                 w_hold_green;
    logic                 w_other_pend;
    logic [2:0]           w_rr_phase;
    logic                 w_night;

`ifdef NIGHT_FLASH_EN
    // r_to_flash: current YELLOW/ALLRED run ends in FLASH.
    // r_from_flash: current ALLRED run was entered from FLASH, so it ends on phase 0.
    logic r_to_flash, w_to_flash_nxt;
    logic r_from_flash, w_from_flash_nxt;
    logic r_flash_on, w_flash_on_nxt;

    assign w_night = night;
`else
    logic w_unused_night;

    assign w_night        = 1'b0;
    assign w_unused_night = night;
`endif

    assign light        = r_light;
    assign active_phase = r_active;
    assign phase_start  = r_phase_start;

    // Any phase other than the green owner waiting for service.
    always_comb begin
        w_other_pend = 1'b0;
        for (int k = 0; k < NUM_DIR; k++) begin
            if (r_pending[k] && (r_active != 3'(k))) w_other_pend = 1'b1;
        end
    end

    // Round-robin pick: first pending phase after the current one, wrapping,
    // with the current phase itself as the last candidate; none -> phase 0.
    always_comb begin
        w_rr_phase = '0;
        for (int d = NUM_DIR; d >= 1; d--) begin
            for (int k = 0; k < NUM_DIR; k++) begin
                if (r_pending[k] && (k == ((int'(r_active) + d) % NUM_DIR))) w_rr_phase = 3'(k);
            end
        end
    end

    // State register plus the timer, owner and pending flags that move with it.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            r_state   <= S_GREEN;
            r_timer   <= '0;
            r_active  <= '0;
            r_pending <= '0;
`ifdef NIGHT_FLASH_EN
            r_to_flash   <= 1'b0;
            r_from_flash <= 1'b0;
            r_flash_on   <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_timer   <= w_timer_nxt;
            r_active  <= w_active_nxt;
            r_pending <= w_pending_nxt;
`ifdef NIGHT_FLASH_EN
            r_to_flash   <= w_to_flash_nxt;
            r_from_flash <= w_from_flash_nxt;
            r_flash_on   <= w_flash_on_nxt;
`endif
        end
    end

    // Next-state logic: interval timing and phase hand-over.
    always_comb begin
        w_state_nxt   = r_state;
        w_timer_nxt   = r_timer;
        w_active_nxt  = r_active;
        w_enter_green = 1'b0;
`ifdef NIGHT_FLASH_EN
        w_to_flash_nxt   = r_to_flash;
        w_from_flash_nxt = r_from_flash;
        w_flash_on_nxt   = r_flash_on;
`endif
        case (r_state)
            S_GREEN: begin
                // Leaving once GREEN_MIN has elapsed also covers the GREEN_MAX
                // bound, since GREEN_MAX >= GREEN_MIN. With nobody waiting the
                // phase rests and the timer parks at GREEN_MAX-1.
                if ((r_timer >= T_GMIN) && (w_other_pend || w_night)) begin
                    w_state_nxt = S_YELLOW;
                    w_timer_nxt = '0;
`ifdef NIGHT_FLASH_EN
                    w_to_flash_nxt = w_night;
`endif
                end else if (r_timer < T_GMAX) begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
            S_YELLOW: begin
                if (r_timer == T_YEL) begin
                    w_state_nxt = S_ALLRED;
                    w_timer_nxt = '0;
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
            S_ALLRED: begin
                if (r_timer == T_AR) begin
                    w_timer_nxt = '0;
`ifdef NIGHT_FLASH_EN
                    if (r_to_flash) begin
                        w_state_nxt    = S_FLASH;
                        w_active_nxt   = '0;
                        w_to_flash_nxt = 1'b0;
                        w_flash_on_nxt = 1'b1;
                    end else if (r_from_flash) begin
                        w_state_nxt      = S_GREEN;
                        w_active_nxt     = '0;
                        w_from_flash_nxt = 1'b0;
                        w_enter_green    = 1'b1;
                    end else
`endif
                    begin
                        w_state_nxt   = S_GREEN;
                        w_active_nxt  = w_rr_phase;
                        w_enter_green = 1'b1;
                    end
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
`ifdef NIGHT_FLASH_EN
            S_FLASH: begin
                if (!night) begin
                    w_state_nxt      = S_ALLRED;
                    w_timer_nxt      = '0;
                    w_from_flash_nxt = 1'b1;
                end else if (r_timer == T_FL) begin
                    w_timer_nxt    = '0;
                    w_flash_on_nxt = ~r_flash_on;
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
`endif
            default: begin
                w_state_nxt  = S_GREEN;
                w_timer_nxt  = '0;
                w_active_nxt = '0;
            end
        endcase
    end

    // Demand latching: a request is ignored only for the phase that stays green
    // across this edge; the phase entering green drops its flag.
    always_comb begin
        w_hold_green  = (r_state == S_GREEN) && (w_state_nxt == S_GREEN);
        w_pending_nxt = r_pending;
        for (int k = 0; k < NUM_DIR; k++) begin
            if (req[k] && !(w_hold_green && (r_active == 3'(k)))) w_pending_nxt[k] = 1'b1;
            if (w_enter_green && (w_active_nxt == 3'(k)))        w_pending_nxt[k] = 1'b0;
        end
    end

    // Output decode from the next state so lamps change on the same edge as state.
    always_comb begin
        w_light_nxt       = {NUM_DIR{LAMP_RED}};
        w_phase_start_nxt = w_enter_green;
        for (int k = 0; k < NUM_DIR; k++) begin
            if (w_active_nxt == 3'(k)) begin
                if (w_state_nxt == S_GREEN)       w_light_nxt[2*k +: 2] = LAMP_GRN;
                else if (w_state_nxt == S_YELLOW) w_light_nxt[2*k +: 2] = LAMP_YEL;
            end
        end
`ifdef NIGHT_FLASH_EN
        if (w_state_nxt == S_FLASH) w_light_nxt[1:0] = w_flash_on_nxt ? LAMP_YEL : LAMP_RED;
`endif
    end

    // Registered outputs.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            r_light       <= LIGHT_RST;
            r_phase_start <= 1'b0;
        end else begin
            r_light       <= w_light_nxt;
            r_phase_start <= w_phase_start_nxt;
        end
    end

endmodule

// File: tb/tb_multi_phase_signal_ctrl.sv
// Testbench for multi_phase_signal_ctrl: directed scenarios plus randomized
// requests / night episodes / resets checked every cycle against a
// segment-queue reference model. Flash checks compile with NIGHT_FLASH_EN.
module tb_multi_phase_signal_ctrl;

  localparam int N    = 4;
  localparam int GMIN = 8;
  localparam int YT   = 3;
  localparam int AT   = 2;
  localparam int FT   = 4;
`ifdef NIGHT_FLASH_EN
  localparam bit FLASH_EN = 1'b1;
`else
  localparam bit FLASH_EN = 1'b0;
`endif

  logic           clock   = 1'b0;
  logic           clear_n = 1'b0;
  logic [N-1:0]   req     = '0;
  logic           night   = 1'b0;
  logic [2*N-1:0] light;
  logic [2:0]     active_phase;
  logic           phase_start;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  multi_phase_signal_ctrl dut (
    .clock        (clock),
    .clear_n      (clear_n),
    .req          (req),
    .night        (night),
    .light        (light),
    .active_phase (active_phase),
    .phase_start  (phase_start)
  );

  // Reference model: green phase with an age, or a queue of upcoming
  // yellow(1)/red(2) cycles ending in a destination, or flash with a count.
  bit m_green, m_flash, m_to_flash, m_back0, m_start;
  int m_age, m_fcnt, m_ph, m_cur;
  bit m_pend[N];
  int m_q[$];

  task automatic model_reset();
    m_green = 1; m_flash = 0; m_to_flash = 0; m_back0 = 0; m_start = 0;
    m_age = 0; m_fcnt = 0; m_ph = 0; m_cur = 0;
    for (int k = 0; k < N; k++) m_pend[k] = 0;
    m_q.delete();
  endtask

  function automatic int choose_next(int cur);
    for (int d = 1; d <= N; d++) if (m_pend[(cur + d) % N]) return (cur + d) % N;
    return 0;
  endfunction

  task automatic model_edge(input logic [N-1:0] r, input logic n);
    bit nf, other, leave, was_green;
    int old_ph;
    nf = FLASH_EN && n;
    was_green = m_green; old_ph = m_ph; leave = 0; m_start = 0;
    if (m_green) begin
      other = 0;
      for (int k = 0; k < N; k++) if (k != m_ph && m_pend[k]) other = 1;
      leave = (m_age + 1 >= GMIN) && (other || nf);
      if (leave) begin
        m_green = 0; m_to_flash = nf;
        repeat (YT) m_q.push_back(1);
        repeat (AT) m_q.push_back(2);
        m_cur = m_q.pop_front();
      end else if (m_age < 100000) m_age++;
    end else if (m_flash) begin
      if (!n) begin
        m_flash = 0; m_back0 = 1;
        repeat (AT) m_q.push_back(2);
        m_cur = m_q.pop_front();
      end else m_fcnt++;
    end else if (m_q.size() != 0) begin
      m_cur = m_q.pop_front();
    end else if (m_to_flash) begin
      m_to_flash = 0; m_flash = 1; m_fcnt = 0; m_ph = 0;
    end else begin
      m_ph = m_back0 ? 0 : choose_next(m_ph);
      m_back0 = 0; m_green = 1; m_age = 0; m_start = 1;
    end
    for (int k = 0; k < N; k++)
      if (r[k] && !(was_green && !leave && k == old_ph)) m_pend[k] = 1;
    if (m_start) m_pend[m_ph] = 0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    logic [2*N-1:0] el;
    el = '0;
    if (m_green) el[2*m_ph +: 2] = 2'b11;
    else if (m_flash) el[1:0] = (((m_fcnt / FT) % 2) == 0) ? 2'b01 : 2'b00;
    else if (m_cur == 1) el[2*m_ph +: 2] = 2'b01;
    check({tag, "/light"},  32'(light), 32'(el));
    check({tag, "/active"}, 32'(active_phase), 32'(m_ph));
    check({tag, "/start"},  32'(phase_start), 32'(m_start));
  endtask

  // One clock: drive inputs (called at negedge), advance model, compare at next negedge.
  task automatic cyc(input logic [N-1:0] r, input logic n);
    req = r; night = n;
    @(posedge clock);
    model_edge(r, n);
    @(negedge clock);
    check_model("cyc");
  endtask

  // Asynchronous reset pulse between clock edges, held across one posedge.
  task automatic do_reset();
    #2 clear_n = 1'b0;
    model_reset();
    #1 check_model("rst");
    @(negedge clock);
    check_model("rst_hold");
    clear_n = 1'b1;
  endtask

  initial begin
    logic [N-1:0] r;
    logic nt;
    bit seen;
    int exp_seq[4];
    exp_seq = '{3, 1, 3, 1};
    nt = 0;

    // Reset state
    model_reset();
    @(negedge clock);
    check("reset_light", 32'(light), 32'h03);
    check("reset_active", 32'(active_phase), 32'h0);
    check("reset_start", 32'(phase_start), 32'h0);
    clear_n = 1'b1;

    // Idle: phase 0 rests green for 100 cycles, no phase_start
    for (int c = 0; c < 100; c++) cyc('0, 1'b0);
    check("idle_light", 32'(light), 32'h03);

    // Single request for phase 2 at cycle 0
    do_reset();
    cyc(4'b0100, 1'b0);
    for (int c = 2; c <= 13; c++) begin
      cyc('0, 1'b0);
      if (c == 7)  check("p2_c7_green0", 32'(light), 32'h03);
      if (c == 8)  check("p2_c8_yellow0", 32'(light), 32'h01);
      if (c == 11) check("p2_c11_allred", 32'(light), 32'h00);
    end
    check("p2_c13_light", 32'(light), 32'h30);
    check("p2_c13_start", 32'(phase_start), 32'h1);
    check("p2_c13_active", 32'(active_phase), 32'h2);

    // Reset mid-yellow of phase 2 abandons the sequence and drops pending
    cyc(4'b1000, 1'b0);
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      cyc('0, 1'b0);
      if (light === 8'h10) seen = 1;
    end
    check("p2_yellow_seen", 32'(seen), 32'h1);
    cyc('0, 1'b0);
    #2 clear_n = 1'b0;
    model_reset();
    #1;
    check("midyel_rst_light", 32'(light), 32'h03);
    check("midyel_rst_active", 32'(active_phase), 32'h0);
    check("midyel_rst_start", 32'(phase_start), 32'h0);
    @(negedge clock);
    clear_n = 1'b1;
    for (int c = 0; c < 30; c++) cyc('0, 1'b0);
    check("midyel_no_pending", 32'(light), 32'h03);

    // Phases 1 and 3 both held: alternation 3,1,3,1
    do_reset();
    cyc(4'b0010, 1'b0);
    for (int c = 2; c <= 13; c++) cyc('0, 1'b0);
    check("rr_p1_active", 32'(active_phase), 32'h1);
    for (int s = 0; s < 4; s++) begin
      seen = 0;
      for (int c = 0; c < 40 && !seen; c++) begin
        cyc(4'b1010, 1'b0);
        if (phase_start === 1'b1) seen = 1;
      end
      check("rr_start_seen", 32'(seen), 32'h1);
      check("rr_served", 32'(active_phase), 32'(exp_seq[s]));
    end

`ifdef NIGHT_FLASH_EN
    // Night flash from phase 0 green
    do_reset();
    for (int c = 1; c <= 21; c++) begin
      cyc('0, 1'b1);
      if (c == 8)  check("fl_c8_yellow", 32'(light), 32'h01);
      if (c == 11) check("fl_c11_red", 32'(light), 32'h00);
      if (c == 13) check("fl_c13_on", 32'(light), 32'h01);
      if (c == 16) check("fl_c16_on", 32'(light), 32'h01);
      if (c == 17) check("fl_c17_off", 32'(light), 32'h00);
      if (c == 21) check("fl_c21_on", 32'(light), 32'h01);
    end
    cyc('0, 1'b0);
    check("fl_exit_red", 32'(light), 32'h00);
    cyc('0, 1'b0);
    cyc('0, 1'b0);
    check("fl_back_green", 32'(light), 32'h03);
    check("fl_back_start", 32'(phase_start), 32'h1);
`else
    // Night has no effect in the default build
    do_reset();
    for (int c = 0; c < 30; c++) cyc('0, 1'b1);
    check("night_ignored", 32'(light), 32'h03);
`endif

    // Randomized requests, night episodes and occasional resets
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < N; k++) r[k] = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 59) == 0) nt = ~nt;
      if ($urandom_range(0, 499) == 0) do_reset();
      else cyc(r, nt);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
